// File: rtl/fe_pc_redirect.sv
// Fetch PC register with a 16-entry direct-mapped BTB.
// Redirects fetch and squashes FE/DE when AGEX disagrees with the prediction.
module fe_pc_redirect #(
   parameter int               DBITS       = 32,
   parameter int               BTB_ENTRIES = 16,
   parameter logic [DBITS-1:0] STARTPC     = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall_FE,
   input  logic             agex_valid,
   input  logic             agex_br_cond,
   input  logic [DBITS-1:0] agex_pc,
   input  logic [DBITS-1:0] agex_target,
   input  logic             agex_pred_taken,
   input  logic [DBITS-1:0] agex_pred_target,
   output logic [DBITS-1:0] pc_FE,
   output logic             pred_taken_FE,
   output logic [DBITS-1:0] pred_target_FE,
   output logic             flush_DE,
   output logic [15:0]      mispred_count
);

   localparam int IW = $clog2(BTB_ENTRIES);
   localparam int TW = DBITS - IW - 2;

   logic [BTB_ENTRIES-1:0] btb_valid;
   logic [TW-1:0]          btb_tag [BTB_ENTRIES];
   logic [DBITS-1:0]       btb_tgt [BTB_ENTRIES];

   logic [IW-1:0]    fe_idx;
   logic [TW-1:0]    fe_tag;
   logic [IW-1:0]    ag_idx;
   logic [TW-1:0]    ag_tag;
   logic             ag_hit;
   logic             mispredict;
   logic [DBITS-1:0] correct_pc;
   logic [DBITS-1:0] pc_seq;
   logic [DBITS-1:0] pc_next;
   logic             sel_redir;
   logic             sel_hold;
   logic             sel_pred;
   logic             sel_seq;

   assign fe_idx = pc_FE[IW+1:2];
   assign fe_tag = pc_FE[DBITS-1:IW+2];
   assign ag_idx = agex_pc[IW+1:2];
   assign ag_tag = agex_pc[DBITS-1:IW+2];

   // Lookup reads the array as it stands; same-cycle writes land next edge.
   assign pred_taken_FE  = btb_valid[fe_idx] &
                           (btb_tag[fe_idx] == fe_tag);
   assign pred_target_FE = pred_taken_FE ? btb_tgt[fe_idx] : '0;

   assign ag_hit = btb_valid[ag_idx] & (btb_tag[ag_idx] == ag_tag);

   assign mispredict = agex_valid &
      ((agex_br_cond != agex_pred_taken) |
       (agex_br_cond & agex_pred_taken &
        (agex_target != agex_pred_target)));

   assign correct_pc = agex_br_cond ? agex_target
                                    : agex_pc + DBITS'(4);
   assign pc_seq     = pc_FE + DBITS'(4);

   assign flush_DE = mispredict & ~reset;

   assign sel_redir = mispredict;
   assign sel_hold  = ~mispredict & stall_FE;
   assign sel_pred  = ~mispredict & ~stall_FE & pred_taken_FE;
   assign sel_seq   = ~mispredict & ~stall_FE & ~pred_taken_FE;

   always_comb begin
      pc_next = pc_seq;
      unique case (1'b1)
         sel_redir: pc_next = correct_pc;
         sel_hold:  pc_next = pc_FE;
         sel_pred:  pc_next = pred_target_FE;
         sel_seq:   pc_next = pc_seq;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_FE         <= STARTPC;
         btb_valid     <= '0;
         mispred_count <= '0;
      end else begin
         pc_FE <= pc_next;
         if (mispredict && (mispred_count != 16'hFFFF))
            mispred_count <= mispred_count + 16'd1;
         // Train on every resolved branch, correct or not.
         if (agex_valid) begin
            if (agex_br_cond) begin
               btb_valid[ag_idx] <= 1'b1;
               btb_tag[ag_idx]   <= ag_tag;
               btb_tgt[ag_idx]   <= agex_target;
            end else if (ag_hit) begin
               btb_valid[ag_idx] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_fe_pc_redirect.sv
// Scenario bench for fe_pc_redirect: expected fetch PCs are queued
// as stimulus is driven and popped after the edge that produces them.
module tb_fe_pc_redirect;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_FE;
   logic        agex_valid;
   logic        agex_br_cond;
   logic [31:0] agex_pc;
   logic [31:0] agex_target;
   logic        agex_pred_taken;
   logic [31:0] agex_pred_target;
   logic [31:0] pc_FE;
   logic        pred_taken_FE;
   logic [31:0] pred_target_FE;
   logic        flush_DE;
   logic [15:0] mispred_count;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_pc_q[$];
   logic [31:0] e;
   logic [15:0] exp_cnt;

   fe_pc_redirect #(.DBITS(32), .BTB_ENTRIES(16), .STARTPC(32'h0)) dut (
      .clk(clk), .reset(reset), .stall_FE(stall_FE),
      .agex_valid(agex_valid), .agex_br_cond(agex_br_cond),
      .agex_pc(agex_pc), .agex_target(agex_target),
      .agex_pred_taken(agex_pred_taken),
      .agex_pred_target(agex_pred_target),
      .pc_FE(pc_FE), .pred_taken_FE(pred_taken_FE),
      .pred_target_FE(pred_target_FE), .flush_DE(flush_DE),
      .mispred_count(mispred_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic agex(input logic v, input logic c,
                       input logic [31:0] p, input logic [31:0] t,
                       input logic pt, input logic [31:0] ptg);
      agex_valid = v; agex_br_cond = c; agex_pc = p;
      agex_target = t; agex_pred_taken = pt; agex_pred_target = ptg;
   endtask

   // Mispredicted not-taken: used to steer fetch to p+4
   task automatic steer(input logic [31:0] p);
      agex(1, 0, p, 32'h0, 1, 32'h0);
      exp_pc_q.push_back(p + 32'd4);
      exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
      tick();
      agex(0, 0, 0, 0, 0, 0);
      checks++; e = exp_pc_q.pop_front();
      if (pc_FE !== e) begin
         errors++;
         $display("FAIL steer_pc: pc_FE=%h expected %h", pc_FE, e);
      end
   endtask

   task automatic test_reset();
      reset = 1; stall_FE = 0; agex(0, 0, 0, 0, 0, 0);
      tick(); tick();
      reset = 0;
      exp_cnt = 16'd0;
      checks++;
      if (pc_FE !== 32'h0 || mispred_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_state: pc=%h cnt=%h expected 0/0",
                  pc_FE, mispred_count);
      end
      checks++;
      if (pred_taken_FE !== 1'b0 || pred_target_FE !== 32'h0) begin
         errors++;
         $display("FAIL reset_pred: taken=%b tgt=%h expected 0/0",
                  pred_taken_FE, pred_target_FE);
      end
   endtask

   task automatic test_free_run();
      for (int i = 1; i <= 3; i++) begin
         exp_pc_q.push_back(32'(i * 4));
         tick();
         checks++; e = exp_pc_q.pop_front();
         if (pc_FE !== e || pred_taken_FE !== 1'b0) begin
            errors++;
            $display("FAIL free_run: pc=%h taken=%b expected %h/0",
                     pc_FE, pred_taken_FE, e);
         end
      end
   endtask

   task automatic test_taken_mispredict();
      agex(1, 1, 32'h10, 32'h40, 0, 32'h0);
      #1;
      checks++;
      if (flush_DE !== 1'b1) begin
         errors++;
         $display("FAIL taken_flush: flush=%b expected 1", flush_DE);
      end
      exp_pc_q.push_back(32'h40); exp_cnt++;
      tick();
      agex(0, 0, 0, 0, 0, 0);
      checks++; e = exp_pc_q.pop_front();
      if (pc_FE !== e || mispred_count !== exp_cnt) begin
         errors++;
         $display("FAIL taken_pc: pc=%h cnt=%h expected %h/%h",
                  pc_FE, mispred_count, e, exp_cnt);
      end
      steer(32'h0C);
      checks++;
      if (pred_taken_FE !== 1'b1 || pred_target_FE !== 32'h40) begin
         errors++;
         $display("FAIL taken_btb: taken=%b tgt=%h expected 1/00000040",
                  pred_taken_FE, pred_target_FE);
      end
   endtask

   task automatic test_not_taken();
      agex(1, 0, 32'h10, 32'h0, 1, 32'h40);
      #1;
      checks++;
      if (flush_DE !== 1'b1 || pred_taken_FE !== 1'b1) begin
         errors++;
         $display("FAIL nt_flush: flush=%b lookup=%b expected 1/1",
                  flush_DE, pred_taken_FE);
      end
      exp_pc_q.push_back(32'h14); exp_cnt++;
      tick();
      agex(0, 0, 0, 0, 0, 0);
      checks++; e = exp_pc_q.pop_front();
      if (pc_FE !== e || mispred_count !== exp_cnt) begin
         errors++;
         $display("FAIL nt_pc: pc=%h cnt=%h expected %h/%h",
                  pc_FE, mispred_count, e, exp_cnt);
      end
      steer(32'h0C);
      checks++;
      if (pred_taken_FE !== 1'b0) begin
         errors++;
         $display("FAIL nt_invalidate: taken=%b expected 0",
                  pred_taken_FE);
      end
   endtask

   task automatic test_jalr();
      agex(1, 1, 32'h20, 32'h80, 1, 32'h80);
      #1;
      checks++;
      if (flush_DE !== 1'b0) begin
         errors++;
         $display("FAIL jalr_ok_flush: flush=%b expected 0", flush_DE);
      end
      exp_pc_q.push_back(32'h14);
      tick();
      checks++; e = exp_pc_q.pop_front();
      if (pc_FE !== e || mispred_count !== exp_cnt) begin
         errors++;
         $display("FAIL jalr_ok_pc: pc=%h cnt=%h expected %h/%h",
                  pc_FE, mispred_count, e, exp_cnt);
      end
      agex(1, 1, 32'h20, 32'h84, 1, 32'h80);
      #1;
      checks++;
      if (flush_DE !== 1'b1) begin
         errors++;
         $display("FAIL jalr_flush: flush=%b expected 1", flush_DE);
      end
      exp_pc_q.push_back(32'h84); exp_cnt++;
      tick();
      agex(0, 0, 0, 0, 0, 0);
      checks++; e = exp_pc_q.pop_front();
      if (pc_FE !== e || mispred_count !== exp_cnt) begin
         errors++;
         $display("FAIL jalr_pc: pc=%h cnt=%h expected %h/%h",
                  pc_FE, mispred_count, e, exp_cnt);
      end
      steer(32'h1C);
      checks++;
      if (pred_taken_FE !== 1'b1 || pred_target_FE !== 32'h84) begin
         errors++;
         $display("FAIL jalr_btb: taken=%b tgt=%h expected 1/00000084",
                  pred_taken_FE, pred_target_FE);
      end
   endtask

   task automatic test_stall();
      stall_FE = 1;
      for (int i = 0; i < 3; i++) begin
         exp_pc_q.push_back(32'h20);
         tick();
         checks++; e = exp_pc_q.pop_front();
         if (pc_FE !== e) begin
            errors++;
            $display("FAIL stall_hold: pc=%h expected %h", pc_FE, e);
         end
      end
      agex(1, 1, 32'h100, 32'h200, 0, 32'h0);
      exp_pc_q.push_back(32'h200); exp_cnt++;
      tick();
      stall_FE = 0; agex(0, 0, 0, 0, 0, 0);
      checks++; e = exp_pc_q.pop_front();
      if (pc_FE !== e || mispred_count !== exp_cnt) begin
         errors++;
         $display("FAIL stall_redirect: pc=%h cnt=%h expected %h/%h",
                  pc_FE, mispred_count, e, exp_cnt);
      end
   endtask

   task automatic test_saturation();
      agex(1, 0, 32'h100, 32'h0, 1, 32'h0);
      for (int i = 0; i < 65536; i++) begin
         exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
         tick();
         if (i == 65527 || i == 65535) begin
            checks++;
            if (mispred_count !== exp_cnt || pc_FE !== 32'h104) begin
               errors++;
               $display("FAIL saturate_%0d: cnt=%h pc=%h expected %h/00000104",
                        i, mispred_count, pc_FE, exp_cnt);
            end
         end
      end
      agex(0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset_mispredict();
      reset = 1;
      agex(1, 1, 32'h30, 32'h300, 0, 32'h0);
      #1;
      checks++;
      if (flush_DE !== 1'b0) begin
         errors++;
         $display("FAIL rst_flush: flush=%b expected 0", flush_DE);
      end
      exp_pc_q.push_back(32'h0); exp_cnt = 16'd0;
      tick();
      reset = 0; agex(0, 0, 0, 0, 0, 0);
      checks++; e = exp_pc_q.pop_front();
      if (pc_FE !== e || mispred_count !== exp_cnt) begin
         errors++;
         $display("FAIL rst_state: pc=%h cnt=%h expected %h/%h",
                  pc_FE, mispred_count, e, exp_cnt);
      end
      steer(32'h2C);
      checks++;
      if (pred_taken_FE !== 1'b0) begin
         errors++;
         $display("FAIL rst_no_write: taken=%b expected 0", pred_taken_FE);
      end
      steer(32'h1C);
      checks++;
      if (pred_taken_FE !== 1'b0 || mispred_count !== exp_cnt) begin
         errors++;
         $display("FAIL rst_btb_clear: taken=%b cnt=%h expected 0/%h",
                  pred_taken_FE, mispred_count, exp_cnt);
      end
   endtask

   task automatic test_wrap();
      steer(32'hFFFF_FFFC);
      steer(32'hFFFF_FFF8);
      exp_pc_q.push_back(32'h0);
      tick();
      checks++; e = exp_pc_q.pop_front();
      if (pc_FE !== e || mispred_count !== exp_cnt) begin
         errors++;
         $display("FAIL wrap_seq: pc=%h cnt=%h expected %h/%h",
                  pc_FE, mispred_count, e, exp_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_taken_mispredict();
      test_not_taken();
      test_jalr();
      test_stall();
      test_saturation();
      test_reset_mispredict();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/fe_pc_redirect.md
# fe_pc_redirect

Fetch-side receiver of the AGEX control-flow resolution interface. It owns the fetch PC register and a 16-entry direct-mapped branch target buffer (BTB). It compares each resolved branch or jump from AGEX against the prediction made at fetch time, redirects the PC on a mismatch, and squashes the FE/DE latches. It sits at the front of the pipeline, feeding the instruction-memory address and the FE latch.

## Interface

Parameters:
- DBITS, 32, data/PC width
- BTB_ENTRIES, 16, BTB depth; power of two; index = PC[log2(BTB_ENTRIES)+1:2]
- STARTPC, 32'h00000000, PC value loaded by reset

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous active-high reset
- stall_FE  in  1  DE hazard stall; hold PC
- agex_valid  in  1  AGEX holds a branch or JAL/JALR this cycle
- agex_br_cond  in  1  resolved taken (1) / not-taken (0)
- agex_pc  in  DBITS  PC of the resolved instruction
- agex_target  in  DBITS  resolved target (JALR target already has bit 0 cleared)
- agex_pred_taken  in  1  prediction made at fetch, carried down the pipeline
- agex_pred_target  in  DBITS  predicted target, carried down the pipeline
- pc_FE  out  DBITS  current fetch PC (registered)
- pred_taken_FE  out  1  BTB hit for pc_FE
- pred_target_FE  out  DBITS  BTB target for pc_FE; 0 on a miss
- flush_DE  out  1  squash the FE→DE and DE→AGEX latches at the next edge
- mispred_count  out  16  saturating mispredict counter

## Operation

- mispredict = agex_valid & ((agex_br_cond != agex_pred_taken) | (agex_br_cond & agex_pred_taken & (agex_target != agex_pred_target))).
- Correct PC = agex_br_cond ? agex_target : agex_pc + 4, computed modulo 2^DBITS.
- Next-PC priority, highest first:
  1. reset → STARTPC
  2. mispredict → correct PC
  3. stall_FE → hold pc_FE
  4. pred_taken_FE → pred_target_FE
  5. otherwise pc_FE + 4, wrapping modulo 2^DBITS
- BTB entry fields: valid, tag = PC[DBITS-1:log2(BTB_ENTRIES)+2], target.
- BTB lookup on pc_FE is combinational. Hit = valid & tag match.
- BTB update, performed at the clock edge whenever agex_valid = 1, whether or not the instruction mispredicted:
  - Taken: write valid=1 with agex_pc's tag and agex_target at agex_pc's index, replacing any occupant.
  - Not taken and the entry at that index matches agex_pc's tag: clear valid.
  - Not taken with no tag match: no change.
- flush_DE = mispredict. It is asserted only in that cycle and is independent of stall_FE.
- mispred_count increments on each mispredict cycle and saturates at 16'hFFFF.
- Reset:
  - pc_FE = STARTPC, all BTB valid bits = 0, mispred_count = 0.
  - Consequently pred_taken_FE = 0 and pred_target_FE = 0 during the cycle after reset.
  - flush_DE is forced to 0 while reset is high.
  - A mispredict arriving in the same cycle as reset is dropped: no redirect, no BTB write, no count.

## Timing

- pc_FE updates one edge after its cause.
- Redirect latency: mispredict in cycle N → pc_FE = correct PC in cycle N+1 → 2-cycle penalty.
- pred_taken_FE, pred_target_FE and flush_DE are combinational, with zero latency from pc_FE and the agex_* inputs.
- BTB read/write collision: when a lookup and an update hit the same index in the same cycle, the lookup returns the pre-write contents (no bypass). The new entry is visible from cycle N+1.
- Mispredict concurrent with stall_FE: the redirect wins and the stall is ignored for that edge.
- Back-to-back mispredicts are handled independently each cycle. In practice the second cannot occur, because flush_DE squashes the younger instruction.

## Test plan

- Reset then free run, no AGEX activity:
  - STARTPC=0.
  - pc_FE must step 0, 4, 8, 12.
  - pred_taken_FE stays 0 throughout.
- Taken BEQ mispredict:
  - Stimulus: agex_valid=1, agex_pc=0x10, agex_br_cond=1, agex_target=0x40, agex_pred_taken=0.
  - flush_DE=1 that cycle; next pc_FE=0x40; mispred_count=1.
  - Once pc_FE later equals 0x10, pred_taken_FE=1 and pred_target_FE=0x40.
- Predicted taken, resolved not taken:
  - Precondition: BTB holds 0x10→0x40.
  - Stimulus: agex_pc=0x10, agex_br_cond=0, agex_pred_taken=1.
  - Next pc_FE=0x14; flush_DE=1; the BTB entry is invalidated.
- JALR target mismatch:
  - Stimulus: pred_taken=1, pred_target=0x80, br_cond=1, target=0x84.
  - Next pc_FE=0x84; the BTB target for that PC is updated to 0x84.
- Stall vs redirect:
  - With stall_FE=1 only, pc_FE holds its value for 3 cycles.
  - With stall_FE=1 and a mispredict (target 0x200) in the same cycle, next pc_FE=0x200.
- Saturation and reset mid-operation:
  - Force 65,536 mispredicts; mispred_count must stick at 0xFFFF.
  - Assert reset together with a mispredict: next pc_FE=STARTPC, count=0, flush_DE=0, and no BTB entry is written.
